// File: rtl/dbus_interconnect_pkg.sv
// Shared types and default memory map for the data-bus interconnect.
// Slave windows are BASE/MASK pairs; the lowest matching index wins.
package dbus_interconnect_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP,
      ST_ERR
   } state_e;

   localparam logic [31:0] RAM_BASE  = 32'h2000_0200;
   localparam logic [31:0] GPO_BASE  = 32'h4000_0000;
   localparam logic [31:0] GPI_BASE  = 32'h4000_0100;
   localparam logic [31:0] GPIO_BASE = 32'h4000_0200;
   localparam logic [31:0] WIN_MASK  = 32'hFFFF_FF00;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dbus_interconnect_addr_match.sv
// Combinational priority address matcher.
// Scans from the top index down so the lowest hit is left in sel_o.
module dbus_interconnect_addr_match #(
   parameter int                  N_SLV = 4,
   parameter int                  SEL_W = 2,
   parameter logic [N_SLV*32-1:0] BASE  = '0,
   parameter logic [N_SLV*32-1:0] MASK  = '0
) (
   input  logic [31:0]      addr_i,
   output logic             hit_o,
   output logic [SEL_W-1:0] sel_o
);

   always_comb begin
      hit_o = 1'b0;
      sel_o = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((addr_i & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) begin
            hit_o = 1'b1;
            sel_o = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: RV32I data port to N_SLV memory-mapped slaves.
// Registered decode, one-hot chip select, wait states, timeout and error replies.
module dbus_interconnect
   import dbus_interconnect_pkg::*;
#(
   parameter int                  N_SLV   = 4,
   parameter int                  DATA_W  = 32,
   parameter logic [N_SLV*32-1:0] BASE    = {GPIO_BASE, GPI_BASE,
                                             GPO_BASE, RAM_BASE},
   parameter logic [N_SLV*32-1:0] MASK    = {N_SLV{WIN_MASK}},
   parameter int                  TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m_req,
   input  logic                    m_we,
   input  logic [31:0]             m_addr,
   input  logic [DATA_W-1:0]       m_wdata,
   input  logic [1:0]              m_bhw,
   output logic [DATA_W-1:0]       m_rdata,
   output logic                    m_ready,
   output logic                    m_err,
   output logic [7:0]              err_cnt,
   output logic [N_SLV-1:0]        s_cs,
   output logic                    s_we,
   output logic [31:0]             s_addr,
   output logic [DATA_W-1:0]       s_wdata,
   output logic [1:0]              s_bhw,
   input  logic [N_SLV*DATA_W-1:0] s_rdata,
   input  logic [N_SLV-1:0]        s_ready
);

   localparam int SEL_W = sel_width(N_SLV);
   localparam int TW    = $clog2(TIMEOUT + 1);

   state_e             state_q;
   logic [SEL_W-1:0]   sel_q;
   logic               we_q;
   logic [31:0]        addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [1:0]         bhw_q;
   logic [TW-1:0]      tcnt_q;
   logic [N_SLV-1:0]   cs_q;
   logic               m_ready_q;
   logic               m_err_q;
   logic [DATA_W-1:0]  m_rdata_q;
   logic [7:0]         err_cnt_q;
   logic [7:0]         err_cnt_d;

   logic               hit;
   logic [SEL_W-1:0]   sel;
   logic [N_SLV-1:0]   cs_set;
   logic [DATA_W-1:0]  rdata_sel;
   logic               rdy_sel;

   dbus_interconnect_addr_match #(
      .N_SLV (N_SLV),
      .SEL_W (SEL_W),
      .BASE  (BASE),
      .MASK  (MASK)
   ) u_match (
      .addr_i (m_addr),
      .hit_o  (hit),
      .sel_o  (sel)
   );

   always_comb begin
      cs_set      = '0;
      cs_set[sel] = 1'b1;
   end

   // Only the selected channel is ever observed.
   assign rdata_sel = s_rdata[int'(sel_q)*DATA_W +: DATA_W];
   assign rdy_sel   = s_ready[sel_q];

   assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         bhw_q     <= '0;
         tcnt_q    <= '0;
         cs_q      <= '0;
         m_ready_q <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
         err_cnt_q <= '0;
      end else begin
         m_ready_q <= 1'b0;
         m_err_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (m_req) begin
                  if (hit) begin
                     state_q <= ST_ACCESS;
                     sel_q   <= sel;
                     we_q    <= m_we;
                     addr_q  <= m_addr;
                     wdata_q <= m_wdata;
                     bhw_q   <= m_bhw;
                     cs_q    <= cs_set;
                     tcnt_q  <= '0;
                  end else begin
                     state_q   <= ST_ERR;
                     m_ready_q <= 1'b1;
                     m_err_q   <= 1'b1;
                     m_rdata_q <= '0;
                     err_cnt_q <= err_cnt_d;
                  end
               end
            end
            ST_ACCESS: begin
               // A ready in the last allowed cycle still counts.
               if (rdy_sel) begin
                  state_q   <= ST_RESP;
                  m_ready_q <= 1'b1;
                  cs_q      <= '0;
                  if (!we_q) begin
                     m_rdata_q <= rdata_sel;
                  end
               end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                  state_q   <= ST_RESP;
                  m_ready_q <= 1'b1;
                  m_err_q   <= 1'b1;
                  m_rdata_q <= '0;
                  cs_q      <= '0;
                  err_cnt_q <= err_cnt_d;
               end else begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               tcnt_q  <= '0;
            end
            ST_ERR: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_rdata = m_rdata_q;
   assign m_ready = m_ready_q;
   assign m_err   = m_err_q;
   assign err_cnt = err_cnt_q;
   assign s_cs    = cs_q;
   assign s_we    = we_q & (|cs_q);
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;
   assign s_bhw   = bhw_q;

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect: table of transactions plus
// hand-written reset-abort, saturation and overlapping-window sequences.
module tb_dbus_interconnect;

   localparam int N = 4;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  bhw;
      int          wt;
      logic [31:0] rd;
      logic [3:0]  cs;
      int          ncs;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      logic [7:0]  ecnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic            m_req, m_we;
   logic [31:0]     m_addr, m_wdata;
   logic [1:0]      m_bhw;
   logic [31:0]     m_rdata;
   logic            m_ready, m_err;
   logic [7:0]      err_cnt;
   logic [N-1:0]    s_cs;
   logic            s_we;
   logic [31:0]     s_addr, s_wdata;
   logic [1:0]      s_bhw;
   logic [N*32-1:0] s_rdata;
   logic [N-1:0]    s_ready;

   logic            o_req;
   logic [31:0]     o_addr;
   logic [31:0]     o_rdata;
   logic            o_ready, o_err;
   logic [7:0]      o_err_cnt;
   logic [N-1:0]    o_cs;
   logic            o_s_we;
   logic [31:0]     o_s_addr, o_s_wdata;
   logic [1:0]      o_s_bhw;
   logic [N*32-1:0] o_s_rdata;
   logic [N-1:0]    o_s_ready;

   int n_pass = 0;
   int n_tot  = 0;
   int wait_cfg = 0;
   int cnt[N];

   dbus_interconnect dut (
      .clk     (clk),
      .reset   (reset),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_bhw   (m_bhw),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .m_err   (m_err),
      .err_cnt (err_cnt),
      .s_cs    (s_cs),
      .s_we    (s_we),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_bhw   (s_bhw),
      .s_rdata (s_rdata),
      .s_ready (s_ready)
   );

   dbus_interconnect #(
      .BASE ({32'h4000_0200, 32'h4000_0100,
              32'h2000_0200, 32'h2000_0200})
   ) u_ovl (
      .clk     (clk),
      .reset   (reset),
      .m_req   (o_req),
      .m_we    (1'b0),
      .m_addr  (o_addr),
      .m_wdata (32'h0),
      .m_bhw   (2'b10),
      .m_rdata (o_rdata),
      .m_ready (o_ready),
      .m_err   (o_err),
      .err_cnt (o_err_cnt),
      .s_cs    (o_cs),
      .s_we    (o_s_we),
      .s_addr  (o_s_addr),
      .s_wdata (o_s_wdata),
      .s_bhw   (o_s_bhw),
      .s_rdata (o_s_rdata),
      .s_ready (o_s_ready)
   );

   // Slave model: selected channel answers after wait_cfg wait cycles;
   // unselected channels hold a stray ready that must be ignored.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (s_cs[i]) begin
            s_ready[i] = (cnt[i] == wait_cfg);
            cnt[i]++;
         end else begin
            cnt[i] = 0;
            s_ready[i] = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
   endtask

   task automatic run(input vec_t v, input string tag);
      logic [3:0]  cs_seen;
      int          ncs, lat;
      logic        bad, got, err_s;
      logic [31:0] rd_s;
      logic [7:0]  ec_s;
      cs_seen = '0; ncs = 0; lat = 99; bad = 1'b0; got = 1'b0;
      err_s = 1'bx; rd_s = 'x; ec_s = 'x;
      for (int i = 0; i < N; i++)
         s_rdata[i*32 +: 32] = v.cs[i] ? v.rd : (32'hDEAD_0000 | 32'(i));
      wait_cfg = v.wt;
      m_req = 1'b1; m_we = v.we; m_addr = v.addr;
      m_wdata = v.wd; m_bhw = v.bhw;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (s_cs != '0) begin
            if (ncs == 0) cs_seen = s_cs;
            ncs++;
            if (s_addr !== v.addr || s_wdata !== v.wd || s_bhw !== v.bhw ||
                s_we !== v.we || s_cs !== cs_seen) bad = 1'b1;
         end
         if (m_ready) begin
            got = 1'b1; lat = c;
            err_s = m_err; rd_s = m_rdata; ec_s = err_cnt;
         end else if (c == 1) begin
            m_addr = ~v.addr; m_wdata = ~v.wd;
            m_we = ~v.we; m_bhw = ~v.bhw;
         end
      end
      chk({tag, " cs"}, 32'(cs_seen), 32'(v.cs));
      chk({tag, " cs_cycles"}, ncs, v.ncs);
      chk({tag, " latency"}, lat, v.lat);
      chk({tag, " err"}, 32'(err_s), 32'(v.err));
      chk({tag, " rdata"}, rd_s, v.rdata);
      chk({tag, " err_cnt"}, 32'(ec_s), 32'(v.ecnt));
      chk({tag, " latch"}, 32'(bad), 32'd0);
      @(posedge clk); #1;
      m_req = 1'b0; m_we = 1'b0;
   endtask

   vec_t tbl[8];
   vec_t r_post;

   initial begin
      int   rdy_cnt, tmo;
      logic got;

      tbl[0] = '{1'b0, 32'h2000_0204, 32'h0, 2'b10, 0, 32'h1234_5678,
                 4'b0001, 1, 2, 1'b0, 32'h1234_5678, 8'd0};
      tbl[1] = '{1'b1, 32'h4000_0010, 32'h0000_00A5, 2'b00, 3, 32'h5555_5555,
                 4'b0010, 4, 5, 1'b0, 32'h1234_5678, 8'd0};
      tbl[2] = '{1'b0, 32'h3000_0000, 32'h0, 2'b10, 0, 32'h6666_6666,
                 4'b0000, 0, 1, 1'b1, 32'h0, 8'd1};
      tbl[3] = '{1'b0, 32'h4000_0104, 32'h0, 2'b01, 1000, 32'h7777_7777,
                 4'b0100, 15, 16, 1'b1, 32'h0, 8'd2};
      tbl[4] = '{1'b0, 32'h4000_01F0, 32'h0, 2'b10, 15, 32'h8888_8888,
                 4'b0100, 15, 16, 1'b1, 32'h0, 8'd3};
      tbl[5] = '{1'b0, 32'h4000_02FC, 32'h0, 2'b10, 1, 32'hCAFE_F00D,
                 4'b1000, 2, 3, 1'b0, 32'hCAFE_F00D, 8'd3};
      tbl[6] = '{1'b0, 32'h4000_00FF, 32'h0, 2'b00, 14, 32'h0BAD_BEEF,
                 4'b0010, 15, 16, 1'b0, 32'h0BAD_BEEF, 8'd3};
      tbl[7] = '{1'b1, 32'h2000_02FF, 32'hFFFF_FFFF, 2'b10, 0, 32'h9999_9999,
                 4'b0001, 1, 2, 1'b0, 32'h0BAD_BEEF, 8'd3};
      r_post = '{1'b0, 32'h4000_0104, 32'h0, 2'b10, 0, 32'h7777_1111,
                 4'b0100, 1, 2, 1'b0, 32'h7777_1111, 8'd0};

      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_bhw = '0;
      s_rdata = '0; s_ready = '1;
      o_req = 1'b0; o_addr = '0; o_s_ready = '1;
      o_s_rdata = {32'h4444_4444, 32'h3333_3333,
                   32'h1111_1111, 32'h0000_0A0A};
      for (int i = 0; i < N; i++) cnt[i] = 0;

      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("rst s_cs", 32'(s_cs), 32'd0);
      chk("rst m_ready", 32'(m_ready), 32'd0);
      chk("rst m_err", 32'(m_err), 32'd0);
      chk("rst m_rdata", m_rdata, 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
      chk("rst s_we", 32'(s_we), 32'd0);
      chk("rst s_addr", s_addr, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Overlapping windows: slave0 and slave1 share a base.
      @(posedge clk); #1;
      o_req = 1'b1; o_addr = 32'h2000_0210;
      @(negedge clk);
      @(negedge clk);
      chk("ovl cs", 32'(o_cs), 32'h1);
      @(negedge clk);
      chk("ovl ready", 32'(o_ready), 32'h1);
      chk("ovl rdata", o_rdata, 32'h0000_0A0A);
      @(posedge clk); #1;
      o_req = 1'b0;

      for (int k = 0; k < 8; k++) run(tbl[k], $sformatf("vec%0d", k));

      // Reset in the middle of a wait-stated access.
      wait_cfg = 1000;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0104;
      repeat (3) @(negedge clk);
      chk("rstmid cs_before", 32'(s_cs), 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("rstmid cs", 32'(s_cs), 32'd0);
      chk("rstmid ready", 32'(m_ready), 32'd0);
      m_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      rdy_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (m_ready) rdy_cnt++;
      end
      chk("rstmid no_resp", rdy_cnt, 0);
      chk("rstmid err_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk); #1;
      run(r_post, "post_rst");

      // Error counter saturation.
      tmo = 0;
      for (int k = 0; k < 300; k++) begin
         m_req = 1'b1; m_we = 1'b0; m_addr = 32'h3000_0000 + 32'(k*4);
         got = 1'b0;
         for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = m_ready;
         end
         if (!got) tmo++;
         @(posedge clk); #1;
         if (k == 253) chk("sat err_cnt_254", 32'(err_cnt), 32'hFE);
      end
      m_req = 1'b0;
      chk("sat timeouts", tmo, 0);
      chk("sat err_cnt", 32'(err_cnt), 32'hFF);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
